score_display_driver: RTL and testbench
=======================================

// Module: score_display_driver
// PURPOSE
//  Parametrised multi-digit 7-segment score driver for the Pong scoreboard. Accepts an unsigned binary
//  score via a valid/ready handshake and converts it sequentially to BCD (shift-add-3, one bit/cycle).
//  Registers per-digit segment patterns with leading-zero blanking, overflow dashes, blank and polarity.
//  Sits between the score counters and the board HEX displays; supersedes the single-digit decoder.
// PARAMETERS
//  DIGITS      4   number of decimal digits driven (1..6)
//  BIN_W       14  width of binary input value (BIN_W <= 20)
//  ACTIVE_LOW  1   1: segment lit = 0 on pins; 0: lit = 1
//  LZ_BLANK    1   1: blank leading zeros (least-significant digit always shown)
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst_n       in   1          synchronous, active-low reset
//  bin_value   in   BIN_W      unsigned score to display
//  load        in   1          valid: bin_value present
//  ready       out  1          block idle, load accepted this cycle if high
//  done        out  1          one-cycle pulse: new pattern now on seg
//  overflow    out  1          last loaded value > 10^DIGITS-1 (sticky until next accepted load)
//  blank       in   1          force all segments off (display dark)
//  seg         out  DIGITS*7   seg[7*d +: 7] = digit d (d=0 least significant); bit0=a .. bit6=g
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, ready=1, done=0, overflow=0, all digits dark
//   (seg = all 1s if ACTIVE_LOW else all 0s). Reset mid-conversion aborts; captured value discarded.
//  Handshake: load accepted at edge E0 iff load & ready. load while ready=0 is ignored, not queued.
//  FSM: IDLE -> CONVERT on accept (capture bin_value, clear BCD reg, bit_cnt=BIN_W-1,
//   compute overflow = bin_value > MAX_VAL, MAX_VAL = 10^DIGITS-1).
//   CONVERT: each edge, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
//   Stay BIN_W edges (E1..E_BIN_W); bit_cnt counts down, exit when bit_cnt==0 -> UPDATE.
//   UPDATE (one cycle): on edge E_(BIN_W+1) load seg registers, done=1, ready=1, -> IDLE.
//  Latency: load accepted -> seg/done valid = BIN_W+1 clocks (15 for defaults). ready low E1..E_BIN_W+1.
//  BCD register width DIGITS*4 + 4 guard bits (guard nibble absorbs values up to 2^BIN_W-1, no wrap).
//  Overflow: all digits show dash (g only); conversion still runs, latency unchanged.
//  Leading zeros (LZ_BLANK=1): digit d>0 dark if it and all higher digits are 0; value 0 shows "0".
//  blank: registered; seg goes dark the edge after blank=1, restores held pattern the edge after
//   blank=0. blank does not stall or cancel a conversion; seg update during blank is stored, not shown.
//  done and blank both high: done still pulses; seg stays dark.
//  seg holds last pattern between conversions; no glitches (all outputs registered).
//  Polarity applied at the final output register only; internal patterns active-high.
//  Digit codes 10..15 cannot occur from the converter; encoder maps them to dark.
// STRUCTURE
//  Shared include score_display_defs.vh: FSM state codes (IDLE, CONVERT, UPDATE), SEG_DARK=7'h00,
//   SEG_DASH=7'h40, active-high segment tables for 0..9.
//  Sub-module seg7_encode: combinational {4-bit digit, dark, dash} -> 7-bit active-high pattern;
//   instantiated DIGITS times via generate. Converter, FSM, blanking and output regs in this module.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> seg=28'hFFFFFFF, ready=1, done=0, overflow=0.
//  2 load 1234 -> done exactly 15 clocks after accept; digits 4,3,2,1 -> seg[6:0]=7'h19, seg[27:21]=7'h79.
//  3 load 7 (LZ_BLANK=1) -> digits 3..1 dark (7'h7F), digit0=7'h78; load 0 -> only digit0 "0" (7'h40).
//  4 load 9999 -> "9999", overflow=0; load 10000 -> all digits 7'h3F (dash), overflow=1.
//  5 load 42 then load 99 on cycle 3 while ready=0 -> 99 ignored, result "42"; blank=1 -> all 7'h7F.
//  6 Reset asserted mid-CONVERT of 5555 -> next cycle dark, ready=1; new load 12 -> "12" in 15 clocks.

Source files
------------

// File: rtl/score_display_driver_pkg.sv
// Shared definitions for the score display driver: FSM states,
// special segment patterns and the active-high 0..9 glyph table.
package score_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    // Active-high segment patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_DARK = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Glyph for a decimal digit; codes 10..15 never come out of the
    // converter, but map them to dark so a corrupted nibble stays invisible.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = SEG_DARK;
        endcase
        return p;
    endfunction

    // 10^n for the small digit counts this block supports (n <= 6)
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < n) r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_driver_seg7_encode.sv
// Single-digit 7-segment encoder. Dash wins over dark so an overflowed
// score shows dashes even where a leading zero would have been blanked.
module seg7_encode
    import score_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dark,
    input  logic       dash,
    output logic [6:0] pattern
);

    // Pick dash, dark or the glyph for the digit
    always_comb begin
        pattern = SEG_DARK;
        if (dash) begin
            pattern = SEG_DASH;
        end else if (!dark) begin
            pattern = seg_digit(digit);
        end
    end

endmodule

// File: rtl/score_display_driver.sv
// Multi-digit score driver: accepts a binary score, converts it to BCD
// one bit per clock (shift-add-3), then registers per-digit segment
// patterns with leading-zero blanking, overflow dashes, blank and polarity.
module score_display_driver
    import score_display_driver_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int BIN_W      = 14,
    parameter int ACTIVE_LOW = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_value,
    input  logic                  load,
    output logic                  ready,
    output logic                  done,
    output logic                  overflow,
    input  logic                  blank,
    output logic [DIGITS*7-1:0]   seg
);

    // One guard nibble above the displayed digits keeps oversized values
    // from wrapping into the visible digits during conversion.
    localparam int BCD_W  = DIGITS * 4 + 4;
    localparam int NIBS   = BCD_W / 4;
    localparam int SEG_W  = DIGITS * 7;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
    // XOR mask that applies output polarity; also the "all dark" pin value
    localparam logic [SEG_W-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

    state_t             state;
    logic [BIN_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
    logic [DIGITS-1:0]  digit_dark;
    logic               higher_zero;
    logic [SEG_W-1:0]   pattern_new;
    logic [SEG_W-1:0]   disp_pat;
    logic [SEG_W-1:0]   pattern_show;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < NIBS; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
        bin_next = {bin_sh[BIN_W-2:0], 1'b0};
    end

    // Leading-zero blanking: a digit above d0 is dark if it and everything above it is zero
    always_comb begin
        digit_dark  = '0;
        higher_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (bcd[4*d +: 4] != 4'd0) higher_zero = 1'b0;
            if ((LZ_BLANK != 0) && (d > 0) && higher_zero) digit_dark[d] = 1'b1;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        seg7_encode u_encode (
            .digit   (bcd[4*d +: 4]),
            .dark    (digit_dark[d]),
            .dash    (overflow),
            .pattern (pattern_new[7*d +: 7])
        );
    end

    // The freshly encoded pattern is shown on the same edge it is latched
    always_comb begin
        pattern_show = disp_pat;
        if (state == ST_UPDATE) pattern_show = pattern_new;
    end

    // Control FSM, converter registers and the polarity/blank output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            bin_sh   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            disp_pat <= '0;
            seg      <= SEG_OFF;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load && ready) begin
                        bin_sh   <= bin_value;
                        bcd      <= '0;
                        bit_cnt  <= CNT_W'(BIN_W - 1);
                        overflow <= (32'(bin_value) > MAX_VAL);
                        ready    <= 1'b0;
                        state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd    <= bcd_next;
                    bin_sh <= bin_next;
                    if (bit_cnt == '0) begin
                        state <= ST_UPDATE;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                ST_UPDATE: begin
                    disp_pat <= pattern_new;
                    done     <= 1'b1;
                    ready    <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
            seg <= blank ? SEG_OFF : (pattern_show ^ SEG_OFF);
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver (default parameters).
// Expected segment words come from a decimal-arithmetic model of the display.
module tb_score_display_driver;

    localparam int DIGITS  = 4;
    localparam int BIN_W   = 14;
    localparam int MAX_VAL = 9999;
    localparam int LAT     = BIN_W + 1;
    localparam logic [27:0] ALL_DARK = 28'hFFFFFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BIN_W-1:0]  bin_value = '0;
    logic              load = 1'b0;
    logic              blank = 1'b0;
    logic              ready;
    logic              done;
    logic              overflow;
    logic [27:0]       seg;

    int checks = 0;
    int errors = 0;

    score_display_driver #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bin_value(bin_value), .load(load),
        .ready(ready), .done(done), .overflow(overflow), .blank(blank), .seg(seg)
    );

    always #5 clk = ~clk;

    // Global watchdog so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Pin-level picture of the display for value v (active-low pins)
    function automatic logic [27:0] model_seg(input int v, input bit blk);
        logic [27:0] r;
        logic [6:0]  g;
        int top, p, dig;
        r = '0;
        if (blk) return ALL_DARK;
        top = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = (v / p) % 10;
            if (dig != 0) top = i;
            p = p * 10;
        end
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = (v / p) % 10;
            if (v > MAX_VAL)   g = 7'h40;
            else if (i > top)  g = 7'h00;
            else               g = glyph(dig);
            r[7*i +: 7] = ~g;
            p = p * 10;
        end
        return r;
    endfunction

    // Wait for ready, present v for one accepting edge, then count edges until done
    task automatic do_load(input int v, output int lat, output bit ovf_acc);
        int w;
        lat = 0;
        ovf_acc = 1'b0;
        w = 0;
        @(negedge clk);
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready) return;
        bin_value = 14'(v);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        ovf_acc = overflow;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (seg !== ALL_DARK) begin errors++; $display("[TB] FAIL reset_seg: got %h expected %h", seg, ALL_DARK); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; bit ovf;
        do_load(1234, lat, ovf);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg !== model_seg(1234, 0)) begin errors++; $display("[TB] FAIL basic_seg: got %h expected %h", seg, model_seg(1234, 0)); end
        checks++; if (seg[6:0] !== 7'h19 || seg[27:21] !== 7'h79) begin errors++; $display("[TB] FAIL basic_digits: got %h/%h expected 19/79", seg[6:0], seg[27:21]); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b expected 1", ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (seg !== model_seg(1234, 0)) begin errors++; $display("[TB] FAIL basic_hold: got %h expected %h", seg, model_seg(1234, 0)); end
    endtask

    task automatic test_leading_zero();
        int lat; bit ovf;
        do_load(7, lat, ovf);
        checks++; if (seg !== model_seg(7, 0)) begin errors++; $display("[TB] FAIL lz_seven: got %h expected %h", seg, model_seg(7, 0)); end
        checks++; if (seg[6:0] !== 7'h78 || seg[27:7] !== 21'h1FFFFF) begin errors++; $display("[TB] FAIL lz_seven_digits: got %h expected %h", seg, {21'h1FFFFF, 7'h78}); end
        do_load(0, lat, ovf);
        checks++; if (seg !== {21'h1FFFFF, 7'h40}) begin errors++; $display("[TB] FAIL lz_zero: got %h expected %h", seg, {21'h1FFFFF, 7'h40}); end
        do_load(305, lat, ovf);
        checks++; if (seg !== model_seg(305, 0)) begin errors++; $display("[TB] FAIL lz_inner_zero: got %h expected %h", seg, model_seg(305, 0)); end
    endtask

    task automatic test_overflow();
        int lat; bit ovf;
        do_load(9999, lat, ovf);
        checks++; if (seg !== model_seg(9999, 0)) begin errors++; $display("[TB] FAIL ovf_9999_seg: got %h expected %h", seg, model_seg(9999, 0)); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_9999_flag: got %b expected 0", overflow); end
        do_load(10000, lat, ovf);
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_at_accept: got %b expected 1", ovf); end
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL ovf_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg !== {4{7'h3F}}) begin errors++; $display("[TB] FAIL ovf_dashes: got %h expected %h", seg, {4{7'h3F}}); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
        do_load(16383, lat, ovf);
        checks++; if (seg !== model_seg(16383, 0)) begin errors++; $display("[TB] FAIL ovf_max: got %h expected %h", seg, model_seg(16383, 0)); end
        do_load(10, lat, ovf);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_ignored_load();
        int lat, extra;
        @(negedge clk);
        bin_value = 14'd42;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); lat++; end
        #1;
        bin_value = 14'd99;
        load = 1'b1;
        @(posedge clk); lat++; #1;
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready: got %b expected 0", ready); end
        while (!done && lat < 100) begin @(posedge clk); lat++; #1; end
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg !== model_seg(42, 0)) begin errors++; $display("[TB] FAIL busy_result: got %h expected %h", seg, model_seg(42, 0)); end
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL busy_not_queued: got %0d extra done expected 0", extra); end
    endtask

    task automatic test_blank();
        int lat; bit ovf;
        @(negedge clk);
        blank = 1'b1;
        @(posedge clk); #1;
        checks++; if (seg !== ALL_DARK) begin errors++; $display("[TB] FAIL blank_dark: got %h expected %h", seg, ALL_DARK); end
        do_load(567, lat, ovf);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL blank_done_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg !== ALL_DARK) begin errors++; $display("[TB] FAIL blank_stays_dark: got %h expected %h", seg, ALL_DARK); end
        @(negedge clk);
        blank = 1'b0;
        @(posedge clk); #1;
        checks++; if (seg !== model_seg(567, 0)) begin errors++; $display("[TB] FAIL blank_restore: got %h expected %h", seg, model_seg(567, 0)); end
    endtask

    task automatic test_reset_mid();
        int lat, extra; bit ovf;
        @(negedge clk);
        bin_value = 14'd5555;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (seg !== ALL_DARK) begin errors++; $display("[TB] FAIL midrst_seg: got %h expected %h", seg, ALL_DARK); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL midrst_discard: got %0d done expected 0", extra); end
        do_load(12, lat, ovf);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg !== model_seg(12, 0)) begin errors++; $display("[TB] FAIL midrst_result: got %h expected %h", seg, model_seg(12, 0)); end
    endtask

    task automatic test_back_to_back();
        int lat, v; bit ovf;
        for (int k = 0; k < 25; k++) begin
            v = (k % 5 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
            do_load(v, lat, ovf);
            checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", v, lat, LAT); end
            checks++; if (seg !== model_seg(v, 0)) begin errors++; $display("[TB] FAIL b2b_seg[%0d]: got %h expected %h", v, seg, model_seg(v, 0)); end
            checks++; if (overflow !== (v > MAX_VAL)) begin errors++; $display("[TB] FAIL b2b_overflow[%0d]: got %b expected %b", v, overflow, (v > MAX_VAL)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leading_zero();
        test_overflow();
        test_ignored_load();
        test_blank();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
